i2c_regfile_arbiter: RTL and testbench

Sequences register-file accesses driven by the I2C subordinate byte stream and shares that single-ported register file with a local host port. It sits between the I2C subordinate (byte strobes already synchronised into clk domain) and on-chip logic. It interprets the first written byte as a register pointer and auto-increments the pointer on each data byte. It also drives hold_clock_low back to the subordinate while read data is being fetched.

---
 rtl/i2c_regfile_arbiter_pkg.sv | 26 ++
 rtl/i2c_regfile_arbiter_regfile.sv | 51 +++++
 rtl/i2c_regfile_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_regfile_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_regfile_arbiter_pkg.sv
// Purpose: shared types and constants for the I2C register-file arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package i2c_arb_pkg;

    // Register data width; the I2C byte stream and register file are byte-wide.
    localparam int DATA_W     = 8;
    // Widest register pointer the request slot can carry; ADDR_W must not exceed it.
    localparam int ADDR_MAX_W = 8;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_PTR   = 2'd1,
        T_WDATA = 2'd2,
        T_RDATA = 2'd3
    } txn_state_t;

    // One posted I2C register access waiting for its execution slot.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ADDR_MAX_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } req_t;

endpackage

// File: rtl/i2c_regfile_arbiter_regfile.sv
// Purpose: NUM_REGS x 8 register array with a single shared read/write port.
// Latency: writes commit at the edge; read data is registered, valid one cycle after acc_re.
// Backpressure: none, one access per cycle is accepted unconditionally.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   acc_we / acc_re     write / read strobe for the single port
//   acc_addr, acc_wdat  access address and write data
//   rd_dat              registered read data (holds until the next read)
//   regs_flat           every register, reg k at [8k+7:8k]
module i2c_regfile
    import i2c_arb_pkg::*;
#(
    parameter int               ADDR_W    = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            acc_we,
    input  logic                            acc_re,
    input  logic [ADDR_W-1:0]               acc_addr,
    input  logic [DATA_W-1:0]               acc_wdat,
    output logic [DATA_W-1:0]               rd_dat,
    output logic [DATA_W*(2**ADDR_W)-1:0]   regs_flat
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            rd_dat <= '0;
        end else begin
            if (acc_we) begin
                regs[acc_addr] <= acc_wdat;
            end
            if (acc_re) begin
                rd_dat <= regs[acc_addr];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[DATA_W*g +: DATA_W] = regs[g];
    end

endmodule

// File: rtl/i2c_regfile_arbiter.sv
// Purpose: turns the I2C subordinate byte stream into pointer/data register accesses and shares the register file with a host port.
// Latency: I2C access executes one edge after it is posted; I2C read data (tx_valid) two edges after tx_req is sampled; host write at grant edge, host read data one cycle after grant.
// Backpressure: I2C has priority; host_gnt drops for the cycle an I2C access is pending; hold_clock_low stretches SCL while read data is fetched.
//
// Ports:
//   clk, rst_n                              clock, asynchronous active-low reset
//   i2c_start/i2c_stop/i2c_rw               transaction framing from the subordinate (rw valid with start, 1 = master reads)
//   i2c_rx_valid/i2c_rx_byte                received byte strobe and data
//   i2c_tx_req -> i2c_tx_valid/i2c_tx_byte  next byte request and its registered answer
//   hold_clock_low                          SCL stretch request while a read is in flight
//   host_req/we/addr/wdata -> host_gnt      host access, held until granted (grant is combinational)
//   host_rvalid/host_rdata                  host read return, one cycle after grant
//   regs_flat                               every register, reg k at [8k+7:8k]
//   err_overrun                             sticky: a new I2C access replaced a pending one
// Optional build macro I2C_ARB_WRITE_LOCK_EN adds input i2c_wr_lock and sticky output err_wlock:
//   I2C data writes arriving while locked are dropped (pointer still advances); host writes unaffected.
module i2c_regfile_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int                ADDR_W    = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i2c_start,
    input  logic                          i2c_stop,
    input  logic                          i2c_rw,
    input  logic                          i2c_rx_valid,
    input  logic [7:0]                    i2c_rx_byte,
    input  logic                          i2c_tx_req,
    output logic [7:0]                    i2c_tx_byte,
    output logic                          i2c_tx_valid,
    output logic                          hold_clock_low,
    input  logic                          host_req,
    input  logic                          host_we,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [7:0]                    host_wdata,
    output logic                          host_gnt,
    output logic                          host_rvalid,
    output logic [7:0]                    host_rdata,
    output logic [8*(2**ADDR_W)-1:0]      regs_flat,
`ifdef I2C_ARB_WRITE_LOCK_EN
    input  logic                          i2c_wr_lock,
    output logic                          err_wlock,
`endif
    output logic                          err_overrun
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    txn_state_t          state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    req_t                pend;

    logic                post_vld;
    logic                post_we;
    logic                wr_lock;
    logic                i2c_exec;
    logic                i2c_rd_done;

    logic                acc_we;
    logic                acc_re;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdat;
    logic [DATA_W-1:0]   rd_dat;

    // Upper pointer bits of the request slot are always zero for ADDR_W < ADDR_MAX_W.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^pend.addr;

`ifdef I2C_ARB_WRITE_LOCK_EN
    logic wlock_hit;
    assign wr_lock   = i2c_wr_lock;
    assign wlock_hit = (state == T_WDATA) && i2c_rx_valid && i2c_wr_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_wlock <= 1'b0;
        end else if (wlock_hit) begin
            err_wlock <= 1'b1;
        end
    end
`else
    assign wr_lock = 1'b0;
`endif

    //------------------------------------------------------------------
    // Transaction FSM and pointer
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= T_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        post_vld  = 1'b0;
        post_we   = 1'b0;

        case (state)
            T_PTR: begin
                if (i2c_rx_valid) begin
                    ptr_nxt   = i2c_rx_byte[ADDR_W-1:0];
                    state_nxt = T_WDATA;
                end
            end
            T_WDATA: begin
                if (i2c_rx_valid) begin
                    // Pointer advances even when a locked write is dropped.
                    ptr_nxt = ptr + PTR_ONE;
                    if (!wr_lock) begin
                        post_vld = 1'b1;
                        post_we  = 1'b1;
                    end
                end
            end
            T_RDATA: begin
                if (i2c_tx_req) begin
                    ptr_nxt  = ptr + PTR_ONE;
                    post_vld = 1'b1;
                end
            end
            default: ;
        endcase

        // Framing overrides the data-driven transition; start beats stop.
        // The pointer is kept so write-pointer / repeated-start / read works.
        if (i2c_start) begin
            state_nxt = i2c_rw ? T_RDATA : T_PTR;
        end else if (i2c_stop) begin
            state_nxt = T_IDLE;
        end
    end

    //------------------------------------------------------------------
    // Register-file port arbitration
    //------------------------------------------------------------------
    // A pending access executes at the next edge unless a newer post
    // replaces it in that same cycle (overrun drops the older one).
    assign i2c_exec = pend.valid && !post_vld;
    assign host_gnt = host_req && !pend.valid;

    always_comb begin
        acc_we   = 1'b0;
        acc_re   = 1'b0;
        acc_addr = host_addr;
        acc_wdat = host_wdata;
        if (i2c_exec) begin
            acc_we   = pend.we;
            acc_re   = !pend.we;
            acc_addr = pend.addr[ADDR_W-1:0];
            acc_wdat = pend.data;
        end else if (host_gnt) begin
            acc_we   = host_we;
            acc_re   = !host_we;
        end
    end

    i2c_regfile #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_we    (acc_we),
        .acc_re    (acc_re),
        .acc_addr  (acc_addr),
        .acc_wdat  (acc_wdat),
        .rd_dat    (rd_dat),
        .regs_flat (regs_flat)
    );

    // Host read data is the register-file output in the cycle after grant.
    assign host_rdata = rd_dat;

    //------------------------------------------------------------------
    // Pending slot, read return path, clock stretch
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend           <= '0;
            err_overrun    <= 1'b0;
            i2c_rd_done    <= 1'b0;
            i2c_tx_valid   <= 1'b0;
            i2c_tx_byte    <= '0;
            hold_clock_low <= 1'b0;
            host_rvalid    <= 1'b0;
        end else begin
            if (post_vld) begin
                pend.valid <= 1'b1;
                pend.we    <= post_we;
                pend.addr  <= ADDR_MAX_W'(ptr);
                pend.data  <= i2c_rx_byte;
                if (pend.valid) begin
                    err_overrun <= 1'b1;
                end
            end else if (i2c_exec) begin
                pend.valid <= 1'b0;
            end

            // Read executed last edge: its data sits in rd_dat now.
            i2c_rd_done  <= i2c_exec && !pend.we;
            i2c_tx_valid <= i2c_rd_done;
            if (i2c_rd_done) begin
                i2c_tx_byte <= rd_dat;
            end

            // Stretch from the read post until its byte is presented; a
            // fresh read post in the same cycle keeps the stretch going.
            if (post_vld && !post_we) begin
                hold_clock_low <= 1'b1;
            end else if (i2c_rd_done) begin
                hold_clock_low <= 1'b0;
            end

            host_rvalid <= host_gnt && !host_we;
        end
    end

endmodule

// File: tb/tb_i2c_regfile_arbiter.sv
// Purpose: self-checking bench for i2c_regfile_arbiter against a register-array/pointer reference model.
// Latency: checks I2C read return two edges after tx_req and two-cycle clock stretch.
// Backpressure: checks host grant stalls for exactly one cycle behind a pending I2C access.
module tb_i2c_regfile_arbiter;

    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  i2c_start, i2c_stop, i2c_rw;
    logic                  i2c_rx_valid;
    logic [7:0]            i2c_rx_byte;
    logic                  i2c_tx_req;
    logic [7:0]            i2c_tx_byte;
    logic                  i2c_tx_valid;
    logic                  hold_clock_low;
    logic                  host_req, host_we;
    logic [ADDR_W-1:0]     host_addr;
    logic [7:0]            host_wdata;
    logic                  host_gnt, host_rvalid;
    logic [7:0]            host_rdata;
    logic [8*NUM_REGS-1:0] regs_flat;
    logic                  err_overrun;
`ifdef I2C_ARB_WRITE_LOCK_EN
    logic                  i2c_wr_lock;
    logic                  err_wlock;
`endif

    int         errors = 0;
    int         checks = 0;
    bit         burst_done;
    logic [7:0] mregs [NUM_REGS];
    logic [3:0] mptr;

    always #5 clk = ~clk;

    i2c_regfile_arbiter #(.ADDR_W(ADDR_W), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .i2c_start(i2c_start), .i2c_stop(i2c_stop), .i2c_rw(i2c_rw),
        .i2c_rx_valid(i2c_rx_valid), .i2c_rx_byte(i2c_rx_byte),
        .i2c_tx_req(i2c_tx_req), .i2c_tx_byte(i2c_tx_byte), .i2c_tx_valid(i2c_tx_valid),
        .hold_clock_low(hold_clock_low),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .regs_flat(regs_flat),
`ifdef I2C_ARB_WRITE_LOCK_EN
        .i2c_wr_lock(i2c_wr_lock), .err_wlock(err_wlock),
`endif
        .err_overrun(err_overrun)
    );

    function automatic logic [7:0] dut_reg(input int i);
        return regs_flat[8*i +: 8];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
        mptr = 4'd0;
    endtask

    task automatic do_start(input logic rw);
        @(negedge clk); i2c_start = 1'b1; i2c_rw = rw;
        @(negedge clk); i2c_start = 1'b0; i2c_rw = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk); i2c_stop = 1'b1;
        @(negedge clk); i2c_stop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); i2c_rx_valid = 1'b1; i2c_rx_byte = b;
        @(negedge clk); i2c_rx_valid = 1'b0;
        @(negedge clk);
    endtask

    // lat: edges after the edge that sampled tx_req; hcnt: cycles with hold high before tx_valid.
    task automatic read_byte(output logic [7:0] b, output int lat, output int hcnt);
        b = 8'h00; lat = -1; hcnt = 0;
        @(negedge clk); i2c_tx_req = 1'b1;
        @(negedge clk); i2c_tx_req = 1'b0;
        for (int e = 0; e < 10; e++) begin
            if (i2c_tx_valid) begin
                b = i2c_tx_byte; lat = e;
                break;
            end
            if (hold_clock_low) hcnt++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic host_op(input logic we, input logic [3:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic rv, output int stall);
        @(negedge clk);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; stall = 0;
        #1;
        while (!host_gnt && stall < 10) begin
            @(negedge clk); #1; stall++;
        end
        @(negedge clk);
        host_req = 1'b0; host_we = 1'b0;
        rv = host_rvalid; rd = host_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++; if (i2c_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %0h want 00", i2c_tx_byte); end
        checks++; if (i2c_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %0b want 0", i2c_tx_valid); end
        checks++; if (hold_clock_low !== 1'b0) begin errors++; $display("FAIL reset_hold: got %0b want 0", hold_clock_low); end
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %0b want 0", host_gnt); end
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b want 0", host_rvalid); end
        checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %0h want 00", host_rdata); end
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b want 0", err_overrun); end
        checks++; if (regs_flat !== {NUM_REGS{8'h00}}) begin errors++; $display("FAIL reset_regs: got %h want all RESET_VAL", regs_flat); end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_write_burst();
        int run, maxrun;
        burst_done = 1'b0; run = 0; maxrun = 0;
        fork
            begin
                do_start(1'b0);
                send_byte(8'h05); mptr = 4'h5;
                send_byte(8'hA1); mregs[mptr] = 8'hA1; mptr++;
                send_byte(8'hB2); mregs[mptr] = 8'hB2; mptr++;
                send_byte(8'hC3); mregs[mptr] = 8'hC3; mptr++;  // lands on reg7 only if ptr reached 7
                do_stop();
                burst_done = 1'b1;
            end
            begin
                host_req = 1'b1; host_we = 1'b0; host_addr = 4'h0;
                for (int k = 0; k < 200 && !burst_done; k++) begin
                    @(negedge clk); #1;
                    if (!host_gnt) run++; else run = 0;
                    if (run > maxrun) maxrun = run;
                end
                host_req = 1'b0;
            end
        join
        checks++; if (dut_reg(5) !== mregs[5]) begin errors++; $display("FAIL burst_reg5: got %0h want %0h", dut_reg(5), mregs[5]); end
        checks++; if (dut_reg(6) !== mregs[6]) begin errors++; $display("FAIL burst_reg6: got %0h want %0h", dut_reg(6), mregs[6]); end
        checks++; if (dut_reg(7) !== mregs[7]) begin errors++; $display("FAIL burst_ptr7: got %0h want %0h", dut_reg(7), mregs[7]); end
        checks++; if (maxrun != 1) begin errors++; $display("FAIL burst_host_stall: got %0d cycles want 1", maxrun); end
    endtask

    task automatic test_read_wrap();
        logic [7:0] b; int lat, hcnt;
        do_start(1'b0);
        send_byte(8'h0F); mptr = 4'hF;
        send_byte(8'h9C); mregs[mptr] = 8'h9C; mptr++;
        send_byte(8'h3D); mregs[mptr] = 8'h3D; mptr++;
        do_start(1'b0);
        send_byte(8'hEF); mptr = 4'hF;   // upper nibble must be ignored
        do_start(1'b1);
        for (int i = 0; i < 2; i++) begin
            read_byte(b, lat, hcnt);
            checks++; if (b !== mregs[mptr]) begin errors++; $display("FAIL wrap_data%0d: got %0h want %0h", i, b, mregs[mptr]); end
            checks++; if (lat != 2) begin errors++; $display("FAIL wrap_latency%0d: got %0d want 2", i, lat); end
            checks++; if (hcnt != 2) begin errors++; $display("FAIL wrap_hold%0d: got %0d want 2", i, hcnt); end
            mptr++;
        end
        do_stop();
    endtask

    task automatic test_conflict();
        int stall;
        do_start(1'b0);
        send_byte(8'h03); mptr = 4'h3;
        @(negedge clk); i2c_rx_valid = 1'b1; i2c_rx_byte = 8'h66;
        @(negedge clk); i2c_rx_valid = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'h3; host_wdata = 8'h55; stall = 0;
        #1;
        while (!host_gnt && stall < 10) begin @(negedge clk); #1; stall++; end
        @(negedge clk); host_req = 1'b0; host_we = 1'b0;
        @(negedge clk);
        mregs[3] = 8'h66; mregs[3] = 8'h55; mptr++;  // I2C first, host last
        checks++; if (stall != 1) begin errors++; $display("FAIL conflict_stall: got %0d want 1", stall); end
        checks++; if (dut_reg(3) !== mregs[3]) begin errors++; $display("FAIL conflict_reg3: got %0h want %0h", dut_reg(3), mregs[3]); end
        do_stop();
    endtask

    task automatic test_random();
        logic [7:0] b, d, rd; logic rv; int lat, hcnt, n, stall; logic [3:0] a;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    do_start(1'b0);
                    b = 8'($urandom); send_byte(b); mptr = b[3:0];
                    n = $urandom_range(1, 4);
                    for (int j = 0; j < n; j++) begin
                        d = 8'($urandom); send_byte(d); mregs[mptr] = d; mptr++;
                    end
                end
                1: begin
                    do_start(1'b1);
                    n = $urandom_range(1, 3);
                    for (int j = 0; j < n; j++) begin
                        read_byte(b, lat, hcnt);
                        checks++; if (b !== mregs[mptr] || lat != 2) begin errors++; $display("FAIL rand_i2c_read: got %0h lat %0d want %0h lat 2", b, lat, mregs[mptr]); end
                        mptr++;
                    end
                end
                2: begin
                    a = 4'($urandom); d = 8'($urandom);
                    host_op(1'b1, a, d, rd, rv, stall);
                    mregs[a] = d;
                    checks++; if (stall != 0) begin errors++; $display("FAIL rand_host_wr_stall: got %0d want 0", stall); end
                end
                default: begin
                    a = 4'($urandom);
                    host_op(1'b0, a, 8'h00, rd, rv, stall);
                    checks++; if (rv !== 1'b1 || rd !== mregs[a]) begin errors++; $display("FAIL rand_host_read: got v%0b %0h want v1 %0h", rv, rd, mregs[a]); end
                end
            endcase
            if ($urandom_range(0, 3) == 0) begin
                do_stop();
                send_byte(8'($urandom));  // idle: must not touch anything
            end
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++; if (dut_reg(i) !== mregs[i]) begin errors++; $display("FAIL rand_reg%0d: got %0h want %0h", i, dut_reg(i), mregs[i]); end
        end
        do_stop();
    endtask

    task automatic test_overrun();
        logic [7:0] rd; logic rv; int stall;
        host_op(1'b1, 4'h8, 8'h5E, rd, rv, stall); mregs[8] = 8'h5E;
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL overrun_before: got %0b want 0", err_overrun); end
        do_start(1'b0);
        send_byte(8'h08); mptr = 4'h8;
        @(negedge clk); i2c_rx_valid = 1'b1; i2c_rx_byte = 8'h11;
        @(negedge clk); i2c_rx_byte = 8'h22;
        @(negedge clk); i2c_rx_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        mptr++; mregs[mptr] = 8'h22; mptr++;  // first byte lost, second written
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %0b want 1", err_overrun); end
        checks++; if (dut_reg(8) !== mregs[8]) begin errors++; $display("FAIL overrun_reg8: got %0h want %0h", dut_reg(8), mregs[8]); end
        checks++; if (dut_reg(9) !== mregs[9]) begin errors++; $display("FAIL overrun_reg9: got %0h want %0h", dut_reg(9), mregs[9]); end
        do_stop();
    endtask

    task automatic test_reset_midread();
        bit seen;
        do_start(1'b1);
        @(negedge clk); i2c_tx_req = 1'b1;
        @(negedge clk); i2c_tx_req = 1'b0;
        checks++; if (hold_clock_low !== 1'b1) begin errors++; $display("FAIL midrd_hold_before: got %0b want 1", hold_clock_low); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hold_clock_low !== 1'b0) begin errors++; $display("FAIL midrd_hold: got %0b want 0", hold_clock_low); end
        checks++; if (i2c_tx_byte !== 8'h00) begin errors++; $display("FAIL midrd_tx_byte: got %0h want 00", i2c_tx_byte); end
        checks++; if (i2c_tx_valid !== 1'b0) begin errors++; $display("FAIL midrd_tx_valid: got %0b want 0", i2c_tx_valid); end
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL midrd_overrun: got %0b want 0", err_overrun); end
        checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL midrd_rdata: got %0h want 00", host_rdata); end
        checks++; if (regs_flat !== {NUM_REGS{8'h00}}) begin errors++; $display("FAIL midrd_regs: got %h want all RESET_VAL", regs_flat); end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin @(negedge clk); if (i2c_tx_valid) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL midrd_late_tx: got tx_valid 1 want 0"); end
        send_byte(8'h44); send_byte(8'h45);
        checks++; if (regs_flat !== {NUM_REGS{8'h00}}) begin errors++; $display("FAIL midrd_idle_rx: got %h want unchanged", regs_flat); end
        do_start(1'b0);
        send_byte(8'h02); mptr = 4'h2;
        send_byte(8'h77); mregs[mptr] = 8'h77; mptr++;
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++; if (dut_reg(i) !== mregs[i]) begin errors++; $display("FAIL midrd_reg%0d: got %0h want %0h", i, dut_reg(i), mregs[i]); end
        end
        do_stop();
    endtask

`ifdef I2C_ARB_WRITE_LOCK_EN
    task automatic test_write_lock();
        logic [7:0] rd; logic rv; int stall;
        i2c_wr_lock = 1'b1;
        do_start(1'b0);
        send_byte(8'h02); mptr = 4'h2;
        send_byte(8'hAB); mptr++;   // dropped
        checks++; if (dut_reg(2) !== mregs[2]) begin errors++; $display("FAIL wlock_drop: got %0h want %0h", dut_reg(2), mregs[2]); end
        checks++; if (err_wlock !== 1'b1) begin errors++; $display("FAIL wlock_flag: got %0b want 1", err_wlock); end
        i2c_wr_lock = 1'b0;
        send_byte(8'hCD); mregs[mptr] = 8'hCD; mptr++;
        checks++; if (dut_reg(3) !== mregs[3]) begin errors++; $display("FAIL wlock_ptr_adv: got %0h want %0h", dut_reg(3), mregs[3]); end
        do_stop();
        i2c_wr_lock = 1'b1;
        host_op(1'b1, 4'h2, 8'h5A, rd, rv, stall); mregs[2] = 8'h5A;
        checks++; if (dut_reg(2) !== mregs[2]) begin errors++; $display("FAIL wlock_host: got %0h want %0h", dut_reg(2), mregs[2]); end
        i2c_wr_lock = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        i2c_start = 1'b0; i2c_stop = 1'b0; i2c_rw = 1'b0;
        i2c_rx_valid = 1'b0; i2c_rx_byte = 8'h00; i2c_tx_req = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 8'h00;
`ifdef I2C_ARB_WRITE_LOCK_EN
        i2c_wr_lock = 1'b0;
`endif
        test_reset();
        test_write_burst();
        test_read_wrap();
        test_conflict();
        test_random();
        test_overrun();
        test_reset_midread();
`ifdef I2C_ARB_WRITE_LOCK_EN
        test_write_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
